// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches source events into pending bits, masks them,
// and drives hwint/irq to CP0. Define IRQ_SYNC_EN to add a two-flop synchronizer per source.
module irq_ctrl #(
  parameter int unsigned NSRC = 6,
  parameter logic [31:0] BASE = 32'h0000_7F20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_i,
  input  logic [31:0]     bus_addr,
  input  logic [31:0]     bus_wdata,
  input  logic [3:0]      bus_byteen,
  output logic [31:0]     bus_rdata,
  output logic            bus_hit,
  output logic [NSRC-1:0] hwint,
  output logic            irq
);

  localparam logic [1:0] OffAck  = 2'd0;
  localparam logic [1:0] OffMask = 2'd1;
  localparam logic [1:0] OffMode = 2'd2;
  localparam logic [1:0] OffId   = 2'd3;

  logic [NSRC-1:0] s;
  logic [NSRC-1:0] s_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] ack;
  logic [NSRC-1:0] rise;
  logic            wr_en;
  logic [2:0]      id_idx;
  logic            unused_bits;

`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = src_i;
`endif

  assign bus_hit = (bus_addr[31:4] == BASE[31:4]);
  assign wr_en   = bus_hit && bus_byteen[0];
  assign rise    = s & ~s_q;

  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:NSRC], bus_byteen[3:1]};

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    ack    = '0;
    if (wr_en) begin
      case (bus_addr[3:2])
        OffAck:  ack    = bus_wdata[NSRC-1:0];
        OffMask: mask_d = bus_wdata[NSRC-1:0];
        OffMode: mode_d = bus_wdata[NSRC-1:0];
        default: ;
      endcase
    end
  end

  // Edge bits: a new rising edge beats a same-cycle ACK. Level bits just follow s.
  assign pending_d = (mode_q & ((pending_q & ~ack) | rise)) | (~mode_q & s);

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q       <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      mode_q    <= '1;
    end else begin
      s_q       <= s;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
    end
  end

  assign hwint = pending_q & mask_q;
  assign irq   = |hwint;

  // Descending scan so the lowest set index wins.
  always_comb begin
    id_idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (hwint[i]) id_idx = 3'(i);
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (bus_hit) begin
      case (bus_addr[3:2])
        OffMask: bus_rdata[NSRC-1:0] = mask_q;
        OffMode: bus_rdata[NSRC-1:0] = mode_q;
        OffId: begin
          bus_rdata[31]  = irq;
          bus_rdata[2:0] = id_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller between the pipeline CPU's hardware-interrupt inputs and up to eight peripheral interrupt sources such as timers and the external interrupt pin. Latches source events into pending bits, masks them, and drives a steady `hwint` vector to CP0. Software configures the block and acknowledges interrupts through M-stage data-bus stores and loads in the 0x7F20–0x7F2F window.

## Interface
- `NSRC`, 6: number of interrupt sources, 1..8; maps to CP0 HWInt.
- `BASE`, 32'h0000_7F20: word-aligned base of the 16-byte register window.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `src_i`  in  NSRC  raw interrupt source lines.
- `bus_addr`  in  32  M-stage data address; bits [1:0] ignored.
- `bus_wdata`  in  32  store data.
- `bus_byteen`  in  4  store byte enables; all zero means no store.
- `bus_rdata`  out  32  load data, combinational from `bus_addr`.
- `bus_hit`  out  1  `bus_addr[31:4] == BASE[31:4]`, combinational.
- `hwint`  out  NSRC  `pending & mask`, driven from registers only.
- `irq`  out  1  `|hwint`.

## Operation
- Registers; all fields are in bits [NSRC-1:0], other bits read 0:
  - +0x0 ACK (write-only, reads 0): write-1-to-clear pending bits, for edge-mode bits only.
  - +0x4 MASK (RW): 1 enables the source.
  - +0x8 MODE (RW): 1 = edge-triggered, 0 = level-sensitive.
  - +0xC ID (RO): bit31 = any `hwint` set; bits [2:0] = lowest set `hwint` index, 0 when none.
- A write takes effect only when `bus_hit=1` and `bus_byteen[0]=1`. Upper byte enables are ignored.
- Sampled source `s`: equals `src_i`, or the synchronizer output when sync is compiled in.
- `s_q` register holds the previous `s`.
- Edge-mode bit: pending set when `s & ~s_q`; cleared by an ACK write with that bit set in `bus_wdata`.
- Level-mode bit: pending is loaded with `s` every cycle; ACK has no effect.
- Set and clear on the same cycle: **set wins**. No interrupt is lost.
- MODE write changes the bit's behaviour from the next cycle. Pending is not cleared by a mode change.
- Masking does not clear pending. Unmasking a pending bit raises `hwint` on the next cycle.
- Reset values:
  - pending = 0, `s_q` = 0, synchronizer = 0.
  - MASK = all ones, MODE = all ones (edge).
  - `hwint` = 0, `irq` = 0.
  - `bus_rdata` = 0 when `bus_hit=0`.
- A source held high through reset produces one edge event on the first cycle after reset deasserts.
- Reset mid-operation discards all pending state; an ACK write in the reset cycle is ignored.

## Timing
- `bus_rdata` and `bus_hit` are combinational, for single-cycle M-stage loads. A read returns pre-write register values when a write happens in the same cycle.
- Source-to-`hwint` latency, `src_i` first high before edge k:
  - without sync: pending=1 after edge k, `hwint` high during cycle k+1 → 1 cycle;
  - with sync: 3 cycles.
- ACK write at edge k: `hwint` low after edge k, unless a new edge on the same bit is captured at edge k.
- MASK write at edge k: `hwint` reflects the new mask after edge k.
- Edge detection needs `src_i` low for at least one sampled cycle between events. Pulses shorter than one clock may be lost.

## Configuration
- `IRQ_SYNC_EN` defined:
  - two-flop synchronizer per source ahead of `s`; latency 3 cycles;
  - level-mode pending lags `src_i` by 2 extra cycles.
- `IRQ_SYNC_EN` undefined: `s = src_i` directly; latency 1 cycle. Sources must then be synchronous to `clk`.

## Test plan
- Reset, NSRC=6, no sync:
  - MASK reads 0x3F, MODE reads 0x3F, ID reads 0, `irq`=0;
  - raise `src_i[2]` → `hwint`=6'b000100 one cycle later, ID reads 0x8000_0002.
- With pending bit 2 set, store 0x4 to 0x7F20 with byteen 4'b0001 → `hwint`=0 next cycle. A store with byteen 4'b0010 leaves it set.
- Sources 1 and 4 both pending:
  - ID reads 0x8000_0001;
  - ACK 0x2 → ID reads 0x8000_0004.
- Write MASK=0x00, then pulse `src_i[0]`:
  - `hwint`=0 while PENDING stays set;
  - write MASK=0x01 → `hwint[0]`=1 next cycle.
- Write MODE=0x00 and hold `src_i[3]` high:
  - `hwint[3]`=1 continuously; ACK 0x8 has no effect;
  - drop `src_i[3]` → `hwint[3]`=0 one cycle later.
- Ack collision: ACK 0x1 at the same edge a new rising edge on `src_i[0]` is captured → `hwint[0]` stays 1. Repeat with `IRQ_SYNC_EN`, checking 3-cycle latency.
